// File: rtl/min_sec_down_if.sv
// Control and display bundle for the mm:ss countdown timer.
// master drives tick/load/presets/start/pause; slave returns the digits and status.
interface min_sec_down_if;
  logic       tick;
  logic       load;
  logic [3:0] ld_min_h;
  logic [3:0] ld_min_l;
  logic [3:0] ld_sec_h;
  logic [3:0] ld_sec_l;
  logic       start;
  logic       pause;
  logic [3:0] min_h;
  logic [3:0] min_l;
  logic [3:0] sec_h;
  logic [3:0] sec_l;
  logic       running;
  logic       zero;
  logic       done;

  modport master (
    output tick, load, ld_min_h, ld_min_l, ld_sec_h, ld_sec_l, start, pause,
    input  min_h, min_l, sec_h, sec_l, running, zero, done
  );

  modport slave (
    input  tick, load, ld_min_h, ld_min_l, ld_sec_h, ld_sec_l, start, pause,
    output min_h, min_l, sec_h, sec_l, running, zero, done
  );
endinterface

// File: rtl/min_sec_down.sv
// BCD mm:ss countdown timer with 1 Hz tick enable and done pulse.
// Define MIN_SEC_DOWN_AUTORELOAD_EN to reload the preset on expiry (periodic timer).
module min_sec_down #(
  parameter int MAX_MIN_H      = 5,
  parameter int DONE_PULSE_CYC = 1
) (
  input logic           clk,
  input logic           rst_n,
  min_sec_down_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  localparam logic [3:0] MAX_H = 4'(MAX_MIN_H);
  localparam logic [7:0] PULSE = 8'(DONE_PULSE_CYC);

  state_t      state_reg, state_next;
  logic [15:0] time_reg, time_next;     // {min_h, min_l, sec_h, sec_l}
  logic [7:0]  done_cnt_reg, done_cnt_next;
  logic [15:0] load_val;
  logic [15:0] dec_val;
  logic        dec_zero;

`ifdef MIN_SEC_DOWN_AUTORELOAD_EN
  logic [15:0] preset_reg;
`endif

  assign load_val = {
    (bus.ld_min_h > MAX_H) ? MAX_H : bus.ld_min_h,
    (bus.ld_min_l > 4'd9)  ? 4'd9  : bus.ld_min_l,
    (bus.ld_sec_h > 4'd5)  ? 4'd5  : bus.ld_sec_h,
    (bus.ld_sec_l > 4'd9)  ? 4'd9  : bus.ld_sec_l
  };

  // Borrow chain; only ever applied when the count is non-zero.
  always_comb begin
    dec_val        = time_reg;
    dec_val[3:0]   = time_reg[3:0] - 4'd1;
    if (time_reg[3:0] == 4'd0) begin
      dec_val[3:0] = 4'd9;
      dec_val[7:4] = time_reg[7:4] - 4'd1;
      if (time_reg[7:4] == 4'd0) begin
        dec_val[7:4]  = 4'd5;
        dec_val[11:8] = time_reg[11:8] - 4'd1;
        if (time_reg[11:8] == 4'd0) begin
          dec_val[11:8]  = 4'd9;
          dec_val[15:12] = time_reg[15:12] - 4'd1;
        end
      end
    end
    dec_zero = (dec_val == 16'd0);
  end

  always_comb begin
    state_next    = state_reg;
    time_next     = time_reg;
    done_cnt_next = (done_cnt_reg != 8'd0) ? done_cnt_reg - 8'd1 : 8'd0;
    if (bus.load) begin
      state_next    = S_IDLE;
      time_next     = load_val;
      done_cnt_next = 8'd0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (!bus.pause && bus.start && !bus.zero) state_next = S_RUN;
        end
        S_RUN: begin
          if (bus.pause) begin
            state_next = S_PAUSE;
          end else if (bus.tick && !bus.zero) begin
            time_next = dec_val;
            if (dec_zero) state_next = S_DONE;
          end
        end
        S_PAUSE: begin
          if (!bus.pause && bus.start) state_next = S_RUN;
        end
        S_DONE: begin
          // One-cycle arming state: the done pulse starts here and times out on its own.
          done_cnt_next = PULSE;
`ifdef MIN_SEC_DOWN_AUTORELOAD_EN
          if (preset_reg != 16'd0) begin
            time_next  = preset_reg;
            state_next = S_RUN;
          end else begin
            state_next = S_IDLE;
          end
`else
          state_next = S_IDLE;
`endif
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_reg    <= S_IDLE;
      time_reg     <= 16'd0;
      done_cnt_reg <= 8'd0;
    end else begin
      state_reg    <= state_next;
      time_reg     <= time_next;
      done_cnt_reg <= done_cnt_next;
    end
  end

`ifdef MIN_SEC_DOWN_AUTORELOAD_EN
  always_ff @(posedge clk) begin
    if (rst_n) begin
      preset_reg <= 16'd0;
    end else if (bus.load) begin
      preset_reg <= load_val;
    end
  end
`endif

  assign bus.min_h   = time_reg[15:12];
  assign bus.min_l   = time_reg[11:8];
  assign bus.sec_h   = time_reg[7:4];
  assign bus.sec_l   = time_reg[3:0];
  assign bus.zero    = (time_reg == 16'd0);
  assign bus.running = (state_reg == S_RUN);
  assign bus.done    = (done_cnt_reg != 8'd0);

endmodule

// File: tb/tb_min_sec_down.sv
// Testbench for min_sec_down: seconds-based reference model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_min_sec_down;

  localparam int MAXH = 5;
  localparam int P    = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   failures = 0;

  min_sec_down_if b();

  min_sec_down #(.MAX_MIN_H(MAXH), .DONE_PULSE_CYC(P)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b)
  );

  always #5 clk = ~clk;

  // Reference model: remaining time as plain seconds.
  int m_secs, m_mode, m_done_left, m_preset;
  bit m_pend, model_ok;
  int n_secs, n_mode, n_done_left, n_preset;
  bit n_pend;

  function automatic int clamp_secs(input logic [3:0] mh, ml, sh, sl);
    int a, c, d, e;
    a = (int'(mh) > MAXH) ? MAXH : int'(mh);
    c = (int'(ml) > 9) ? 9 : int'(ml);
    d = (int'(sh) > 5) ? 5 : int'(sh);
    e = (int'(sl) > 9) ? 9 : int'(sl);
    return (a * 10 + c) * 60 + d * 10 + e;
  endfunction

  function automatic logic [15:0] to_bcd(input int s);
    int m, sc;
    m  = s / 60;
    sc = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10)};
  endfunction

  always_comb begin
    n_secs      = m_secs;
    n_mode      = m_mode;
    n_preset    = m_preset;
    n_pend      = 1'b0;
    n_done_left = (m_done_left > 0) ? m_done_left - 1 : 0;
    if (rst_n) begin
      n_secs = 0; n_mode = M_IDLE; n_preset = 0; n_done_left = 0;
    end else if (b.load) begin
      n_secs      = clamp_secs(b.ld_min_h, b.ld_min_l, b.ld_sec_h, b.ld_sec_l);
      n_preset    = n_secs;
      n_mode      = M_IDLE;
      n_done_left = 0;
    end else if (m_pend) begin
      n_done_left = P;
      n_mode      = M_IDLE;
`ifdef MIN_SEC_DOWN_AUTORELOAD_EN
      if (m_preset > 0) begin
        n_secs = m_preset;
        n_mode = M_RUN;
      end
`endif
    end else if (m_mode == M_IDLE) begin
      if (b.start && !b.pause && m_secs != 0) n_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (b.pause) n_mode = M_PAUSE;
      else if (b.tick && m_secs > 0) begin
        n_secs = m_secs - 1;
        if (n_secs == 0) begin
          n_pend = 1'b1;
          n_mode = M_IDLE;
        end
      end
    end else begin
      if (b.start && !b.pause) n_mode = M_RUN;
    end
  end

  always @(posedge clk) begin
    m_secs      <= n_secs;
    m_mode      <= n_mode;
    m_preset    <= n_preset;
    m_pend      <= n_pend;
    m_done_left <= n_done_left;
    if (rst_n) model_ok <= 1'b1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      checks += 4;
      if ({b.min_h, b.min_l, b.sec_h, b.sec_l} !== to_bcd(m_secs)) begin
        failures++;
        $display("FAIL model_digits t=%0t actual=%h expected=%h", $time,
                 {b.min_h, b.min_l, b.sec_h, b.sec_l}, to_bcd(m_secs));
      end
      if (b.running !== (m_mode == M_RUN)) begin
        failures++;
        $display("FAIL model_running t=%0t actual=%b expected=%b", $time, b.running, m_mode == M_RUN);
      end
      if (b.zero !== (m_secs == 0)) begin
        failures++;
        $display("FAIL model_zero t=%0t actual=%b expected=%b", $time, b.zero, m_secs == 0);
      end
      if (b.done !== (m_done_left > 0)) begin
        failures++;
        $display("FAIL model_done t=%0t actual=%b expected=%b", $time, b.done, m_done_left > 0);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  function automatic logic [31:0] digits();
    return {16'd0, b.min_h, b.min_l, b.sec_h, b.sec_l};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] mh, ml, sh, sl);
    b.load = 1'b1; b.ld_min_h = mh; b.ld_min_l = ml; b.ld_sec_h = sh; b.ld_sec_l = sl;
    cyc();
    b.load = 1'b0;
  endtask

  task automatic do_start();
    b.start = 1'b1;
    cyc();
    b.start = 1'b0;
  endtask

  task automatic do_tick();
    b.tick = 1'b1;
    cyc();
    b.tick = 1'b0;
    cyc();
  endtask

  int done_cnt, rises;
  bit first_done, prev_done;

  initial begin
    b.tick = 0; b.load = 0; b.start = 0; b.pause = 0;
    b.ld_min_h = 0; b.ld_min_l = 0; b.ld_sec_h = 0; b.ld_sec_l = 0;
    rst_n = 1'b1;
    cyc(); cyc();
    rst_n = 1'b0;
    chk("por_digits", digits(), 32'h0000);
    chk("por_done", b.done, 0);

    // Reset mid-run at 12:34
    do_load(4'd1, 4'd2, 4'd3, 4'd4);
    do_start();
    chk("run_running", b.running, 1);
    do_tick();
    chk("run_12_33", digits(), 32'h1233);
    rst_n = 1'b1;
    cyc(); cyc();
    rst_n = 1'b0;
    chk("rst_digits", digits(), 32'h0000);
    chk("rst_running", b.running, 0);
    chk("rst_done", b.done, 0);

    // Clamp
    do_load(4'hF, 4'hC, 4'h7, 4'hA);
    chk("clamp_5959", digits(), 32'h5959);
    do_start();
    do_tick();
    chk("clamp_tick_5958", digits(), 32'h5958);

    // Borrow chain
    do_load(4'd1, 4'd0, 4'd0, 4'd0);
    do_start();
    do_tick();
    chk("borrow_0959", digits(), 32'h0959);
    do_load(4'd0, 4'd1, 4'd0, 4'd0);
    do_start();
    do_tick();
    chk("borrow_0059", digits(), 32'h0059);

`ifndef MIN_SEC_DOWN_AUTORELOAD_EN
    // Expiry
    do_load(4'd0, 4'd0, 4'd0, 4'd2);
    do_start();
    do_tick();
    b.tick = 1'b1;
    cyc();
    b.tick = 1'b0;
    chk("exp_0000", digits(), 32'h0000);
    chk("exp_done_not_yet", b.done, 0);
    done_cnt = 0;
    first_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (i == 0) first_done = b.done;
      if (b.done) done_cnt++;
    end
    chk("exp_done_first", first_done, 1);
    chk("exp_done_len", done_cnt, P);
    repeat (3) do_tick();
    chk("exp_hold_0000", digits(), 32'h0000);
    chk("exp_idle", b.running, 0);
`endif

    // Load aborts a done pulse
    do_load(4'd0, 4'd0, 4'd0, 4'd1);
    do_start();
    b.tick = 1'b1;
    cyc();
    b.tick = 1'b0;
    cyc();
    chk("abort_done_up", b.done, 1);
    do_load(4'd0, 4'd0, 4'd0, 4'd5);
    chk("abort_done_gone", b.done, 0);
    chk("abort_0005", digits(), 32'h0005);

    // Pause and conflicts
    do_load(4'd0, 4'd0, 4'd3, 4'd0);
    do_start();
    b.pause = 1'b1; b.tick = 1'b1;
    cyc();
    b.pause = 1'b0; b.tick = 1'b0;
    chk("pause_tick_0030", digits(), 32'h0030);
    chk("pause_running", b.running, 0);
    repeat (3) do_tick();
    chk("pause_hold_0030", digits(), 32'h0030);
    do_start();
    do_tick();
    chk("resume_0029", digits(), 32'h0029);
    b.start = 1'b1; b.pause = 1'b1;
    cyc();
    b.start = 1'b0; b.pause = 1'b0;
    chk("start_pause_wins", b.running, 0);

    // Start at zero
    do_load(4'd0, 4'd0, 4'd0, 4'd0);
    do_start();
    chk("zero_start_running", b.running, 0);
    cyc();
    chk("zero_start_done", b.done, 0);
    chk("zero_flag", b.zero, 1);

`ifdef MIN_SEC_DOWN_AUTORELOAD_EN
    // Periodic reload
    do_load(4'd0, 4'd0, 4'd0, 4'd2);
    do_start();
    rises = 0;
    prev_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b.tick = 1'b1;
      cyc();
      b.tick = 1'b0;
      if (b.done && !prev_done) rises++;
      prev_done = b.done;
      for (int j = 0; j < 3; j++) begin
        cyc();
        if (b.done && !prev_done) rises++;
        prev_done = b.done;
      end
    end
    chk("auto_pulses", rises, 2);
    chk("auto_0002", digits(), 32'h0002);
    chk("auto_running", b.running, 1);
`endif

    cyc(); cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/min_sec_down.md
Name: min_sec_down

Overview:
- BCD countdown timer, mm:ss format. It is the down-counting counterpart of the up-counting minute/second chain in the clock design.
- The user loads a preset, starts the timer, and it decrements once per 1 Hz tick.
- At 00:00 it stops and raises a one-cycle done pulse for the alarm/buzzer logic.
- It shares the 1 Hz enable and display path with the clock counters.

Parameters:
- MAX_MIN_H, 5, largest allowed tens-of-minutes digit. Load values above it clamp to it.
- DONE_PULSE_CYC, 1, number of cycles done stays high after reaching zero (1..255).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-high (port name per codebase convention; polarity fixed: 1 = reset)
- tick  in  1  1 Hz enable, one clk cycle wide
- load  in  1  capture ld_* into counter and enter IDLE
- ld_min_h  in  4  preset tens of minutes
- ld_min_l  in  4  preset minutes units
- ld_sec_h  in  4  preset tens of seconds
- ld_sec_l  in  4  preset seconds units
- start  in  1  begin/resume counting
- pause  in  1  suspend counting
- min_h  out  4  current tens of minutes
- min_l  out  4  current minutes units
- sec_h  out  4  current tens of seconds
- sec_l  out  4  current seconds units
- running  out  1  high in RUN state
- zero  out  1  counter equals 00:00 (combinational from digits)
- done  out  1  pulse on reaching zero

Behaviour:
- Reset (rst_n=1 at clk edge):
  - all digits 0, state IDLE, running=0, done=0, done counter 0.
  - The saved preset register is cleared to 00:00.
- States: IDLE, RUN, PAUSE, DONE.
- Load clamping:
  - ld_min_l >9 → 9; ld_sec_l >9 → 9; ld_sec_h >5 → 5; ld_min_h >MAX_MIN_H → MAX_MIN_H.
  - The clamped value is written to the digits and to the preset register next cycle.
- Priority per cycle: reset > load > pause > start > tick.
- load is accepted in any state. It always forces IDLE and aborts any done pulse (done=0 next cycle).
- IDLE:
  - start=1 and zero=0 → RUN.
  - start=1 and zero=1 → stay IDLE, no done.
- RUN:
  - pause=1 → PAUSE; a tick in the same cycle is ignored.
  - tick=1 → decrement one second.
- PAUSE: start=1 → RUN. tick is ignored.
- Decrement (borrow chain, all registered, one cycle latency from tick):
  - sec_l>0: sec_l-1.
  - Otherwise sec_l=9 and borrow: sec_h>0 → sec_h-1, else sec_h=5 and borrow to min_l.
  - min_l>0 → min_l-1, else min_l=9 and borrow to min_h-1.
  - Decrement is never applied at 00:00.
- Reaching zero:
  - On the tick that makes the digits 00:00 (e.g. 00:01 → 00:00), next state is DONE and done=1 starting the following cycle.
  - done lasts DONE_PULSE_CYC cycles, then → IDLE with digits held at 00:00.
- DONE: start and tick are ignored; pause is ignored.
- running = (state==RUN). zero is combinational and valid in every state.
- Simultaneous start+pause: pause wins.

Optional Feature:
- Macro: MIN_SEC_DOWN_AUTORELOAD_EN.
- Defined: on reaching 00:00, done pulses as normal, but the digits reload from the preset register in the same cycle done rises and the state goes to RUN (periodic timer). If the preset is 00:00, go to IDLE instead.
- Undefined: no reload. Behaviour is exactly as above and the preset register may be optimised away.

Test Plan:
- Reset: rst_n=1 for 2 cycles mid-RUN at 12:34 → all digits 0, running=0, done=0, state IDLE.
- Clamp: load ld=F,C,7,A → digits read 5:9:5:9 (59:59). Then start plus 1 tick → 59:58.
- Borrow chain: load 10:00, start, 1 tick → 09:59. Load 01:00, 1 tick → 00:59.
- Expiry: load 00:02, start, 2 ticks → 00:00. done high for exactly DONE_PULSE_CYC cycles starting 1 cycle after the second tick's decrement. Then IDLE; further ticks leave 00:00.
- Pause/conflicts:
  - RUN at 00:30, pause with tick in the same cycle → stays 00:30. 3 ticks in PAUSE → 00:30.
  - start, 1 tick → 00:29.
  - start+pause together in RUN → PAUSE.
  - start at 00:00 in IDLE → no state change, no done.
- Autoreload (macro defined): load 00:02, start, 4 ticks → done pulses twice, digits 00:02 after each expiry, running stays 1.
